// File: rtl/dict_pkg.sv
// Shared types and helpers for the multi-slot dictionary bank.
package dict_pkg;

    typedef enum logic [1:0] {
        SLOT_EMPTY,
        SLOT_LOADING,
        SLOT_READY
    } slot_state_t;

    // Reference beat layout for the default value_t/TAG_WIDTH; the bank builds its own from parameters.
    typedef struct packed {
        logic [31:0] value;
        logic [9:0]  tag;
        logic        last;
        logic        miss;
    } dict_out_beat_t;

    function automatic int unsigned slot_next(input int unsigned ptr, input int unsigned num_slots);
        return (ptr + 1 >= num_slots) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/dict_read_fifo.sv
// Output skid FIFO for looked-up beats; sized so every accepted id always has a free entry.
module dict_read_fifo
    import dict_pkg::*;
#(
    parameter type         beat_t = dict_out_beat_t,
    parameter int unsigned DEPTH  = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_push,
    input  beat_t i_data,
    input  logic  i_pop,
    output logic  o_valid,
    output beat_t o_data
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    beat_t         r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_pop   = i_pop && (r_count != '0);
    assign o_valid = (r_count != '0);
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + CW'(i_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/multi_slot_dictionary_bank.sv
// Ping-pong dictionary bank: slot w loads a column while slot r serves id lookups.
// Optional miss detection is enabled by defining LIBSTF_DICT_MISS_EN.
module multi_slot_dictionary_bank
    import dict_pkg::*;
#(
    parameter type          value_t      = logic [31:0],
    parameter int unsigned  DEPTH        = 1024,
    parameter int unsigned  NUM_SLOTS    = 2,
    parameter int unsigned  TAG_WIDTH    = 10,
    parameter int unsigned  READ_LATENCY = 2,
    localparam int unsigned VALUE_W      = $bits(value_t),
    localparam int unsigned ID_W         = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [VALUE_W-1:0]   in_value_data,
    input  logic                 in_value_last,
    input  logic                 in_value_valid,
    output logic                 in_value_ready,
    input  logic [ID_W-1:0]      in_id_data,
    input  logic [TAG_WIDTH-1:0] in_id_tag,
    input  logic                 in_id_last,
    input  logic                 in_id_valid,
    output logic                 in_id_ready,
    output logic [VALUE_W-1:0]   out_data,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 out_last,
`ifdef LIBSTF_DICT_MISS_EN
    output logic                 out_miss,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NUM_SLOTS-1:0] slot_ready
);

    localparam int unsigned SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int unsigned FILL_W = ID_W + 1;
    localparam int unsigned FIFO_D = READ_LATENCY + 2;
    localparam int unsigned INF_W  = $clog2(FIFO_D + 1);
    localparam int unsigned MEM_AW = SLOT_W + ID_W;
    localparam int unsigned RL     = READ_LATENCY;

    typedef struct packed {
        value_t               value;
        logic [TAG_WIDTH-1:0] tag;
        logic                 last;
        logic                 miss;
    } beat_t;

    slot_state_t       r_state     [NUM_SLOTS];
    slot_state_t       w_state_nxt [NUM_SLOTS];
    logic [FILL_W-1:0] r_fill      [NUM_SLOTS];
    logic [FILL_W-1:0] w_fill_nxt  [NUM_SLOTS];
    logic [SLOT_W-1:0] r_wptr, r_rptr, w_wptr_nxt, w_rptr_nxt;
    logic [INF_W-1:0]  r_inflight;

    value_t               r_mem   [1 << MEM_AW];
    value_t               r_pdata [RL];
    logic [RL-1:0]        r_pv, r_pl, r_pm;
    logic [TAG_WIDTH-1:0] r_ptag  [RL];

    logic              w_val_fire, w_val_we, w_id_fire, w_out_fire, w_miss;
    logic [MEM_AW-1:0] w_waddr, w_raddr;
    beat_t             w_push_beat, w_head;

    assign in_value_ready = (r_state[r_wptr] != SLOT_READY);
    assign in_id_ready    = (r_state[r_rptr] == SLOT_READY) && (r_inflight < INF_W'(FIFO_D));
    assign w_val_fire     = in_value_valid && in_value_ready;
    assign w_id_fire      = in_id_valid && in_id_ready;
    assign w_out_fire     = out_valid && out_ready;
    // Beats past DEPTH are accepted but never written, so fill saturates at DEPTH.
    assign w_val_we       = w_val_fire && (r_fill[r_wptr] < FILL_W'(DEPTH));
    assign w_waddr        = {r_wptr, r_fill[r_wptr][ID_W-1:0]};
    assign w_raddr        = {r_rptr, in_id_data};

`ifdef LIBSTF_DICT_MISS_EN
    assign w_miss = ({1'b0, in_id_data} >= r_fill[r_rptr]);
`else
    assign w_miss = 1'b0;
`endif

    // Fill count doubles as slot length once READY; it is cleared when the slot is drained.
    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill;
        w_wptr_nxt  = r_wptr;
        w_rptr_nxt  = r_rptr;
        if (w_val_fire) begin
            if (w_val_we) w_fill_nxt[r_wptr] = r_fill[r_wptr] + FILL_W'(1);
            w_state_nxt[r_wptr] = in_value_last ? SLOT_READY : SLOT_LOADING;
            if (in_value_last) w_wptr_nxt = SLOT_W'(slot_next(32'(r_wptr), NUM_SLOTS));
        end
        if (w_id_fire && in_id_last) begin
            w_state_nxt[r_rptr] = SLOT_EMPTY;
            w_fill_nxt[r_rptr]  = '0;
            w_rptr_nxt          = SLOT_W'(slot_next(32'(r_rptr), NUM_SLOTS));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < int'(NUM_SLOTS); s++) begin
                r_state[s] <= SLOT_EMPTY;
                r_fill[s]  <= '0;
            end
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_inflight <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fill     <= w_fill_nxt;
            r_wptr     <= w_wptr_nxt;
            r_rptr     <= w_rptr_nxt;
            r_inflight <= r_inflight + INF_W'(w_id_fire) - INF_W'(w_out_fire);
        end
    end

    // Read-first: the accept-cycle read sees the old word even if the slot is being refilled.
    always_ff @(posedge clk) begin
        if (w_val_we) r_mem[w_waddr] <= value_t'(in_value_data);
        if (w_id_fire) r_pdata[0] <= r_mem[w_raddr];
        for (int i = 1; i < int'(RL); i++) r_pdata[i] <= r_pdata[i-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv <= '0;
            r_pl <= '0;
            r_pm <= '0;
            for (int i = 0; i < int'(RL); i++) r_ptag[i] <= '0;
        end else begin
            r_pv[0]   <= w_id_fire;
            r_pl[0]   <= in_id_last;
            r_pm[0]   <= w_miss;
            r_ptag[0] <= in_id_tag;
            for (int i = 1; i < int'(RL); i++) begin
                r_pv[i]   <= r_pv[i-1];
                r_pl[i]   <= r_pl[i-1];
                r_pm[i]   <= r_pm[i-1];
                r_ptag[i] <= r_ptag[i-1];
            end
        end
    end

    always_comb begin
        w_push_beat.value = r_pm[RL-1] ? '0 : r_pdata[RL-1];
        w_push_beat.tag   = r_ptag[RL-1];
        w_push_beat.last  = r_pl[RL-1];
        w_push_beat.miss  = r_pm[RL-1];
    end

    dict_read_fifo #(
        .beat_t (beat_t),
        .DEPTH  (FIFO_D)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_pv[RL-1]),
        .i_data  (w_push_beat),
        .i_pop   (w_out_fire),
        .o_valid (out_valid),
        .o_data  (w_head)
    );

    assign out_data = w_head.value;
    assign out_tag  = w_head.tag;
    assign out_last = w_head.last;
`ifdef LIBSTF_DICT_MISS_EN
    assign out_miss = w_head.miss;
`else
    logic w_unused_miss;
    assign w_unused_miss = w_head.miss;
`endif

    always_comb begin
        slot_ready = '0;
        for (int s = 0; s < int'(NUM_SLOTS); s++) slot_ready[s] = (r_state[s] == SLOT_READY);
    end

endmodule
